// File: rtl/instr_fetcher_if.sv
// rtl/instr_fetcher_if.sv - program-memory read channel between the fetch stage and program memory
interface instr_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch stage with read timeout; optional INSTR_FETCHER_LAST_PC_CACHE_EN
// adds a one-entry last-PC cache that serves repeat fetches without a memory access.
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  instr_fetcher_if.master                  mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error,
  output logic                             fetch_hit
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                             state_q, state_d;
  logic                               valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q, instr_d;
  logic                               err_q, err_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               cache_hit;

`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
  logic                               hit_q, hit_d;
  logic                               cv_q, cv_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   tag_q, tag_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   cdata_q, cdata_d;

  assign cache_hit = cv_q && (tag_q == current_pc);
  assign fetch_hit = hit_q;
`else
  assign cache_hit = 1'b0;
  assign fetch_hit = 1'b0;
`endif

  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;
  assign fetcher_state        = state_q;
  assign instruction          = instr_q;
  assign fetch_error          = err_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
    hit_d   = 1'b0;
    cv_d    = cv_q;
    tag_d   = tag_q;
    cdata_d = cdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            state_d = FETCHED;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
            instr_d = cdata_q;
            hit_d   = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            cnt_d   = '0;
            state_d = FETCHING;
          end
        end
      end
      FETCHING: begin
        // Ready is checked first so a response on the last timeout cycle still counts.
        if (mem.mem_read_ready) begin
          instr_d = mem.mem_read_data;
          valid_d = 1'b0;
          state_d = FETCHED;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
          cv_d    = 1'b1;
          tag_d   = addr_q;
          cdata_d = mem.mem_read_data;
`endif
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          instr_d = '0;
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = FETCHED;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
          cv_d    = 1'b0;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
      hit_q   <= 1'b0;
      cv_q    <= 1'b0;
      tag_q   <= '0;
      cdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef INSTR_FETCHER_LAST_PC_CACHE_EN
      hit_q   <= hit_d;
      cv_q    <= cv_d;
      tag_q   <= tag_d;
      cdata_q <= cdata_d;
`endif
    end
  end

endmodule
